mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage, successor to the single-shot HI/LO unit. It computes products and quotients with a radix-2 shift-add/restoring datapath instead of behavioural `*`/`/`. It adds accumulate modes (madd/maddu/msub/msubu), a flush input for exception cancellation, and defined divide-by-zero and overflow results. The hazard unit stalls on `busy | start`; mfhi/mflo read `dataout` combinationally.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_step.sv | 33 +++
 rtl/mdu_iter.sv | 173 +++++++++++++++++
 tb/tb_mdu_iter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the start-class decode.
package mdu_pkg;

    localparam int OPW = 4;

    localparam int unsigned OP_NONE  = 0;
    localparam int unsigned OP_MULT  = 1;
    localparam int unsigned OP_MULTU = 2;
    localparam int unsigned OP_DIV   = 3;
    localparam int unsigned OP_DIVU  = 4;
    localparam int unsigned OP_MFHI  = 5;
    localparam int unsigned OP_MFLO  = 6;
    localparam int unsigned OP_MTHI  = 7;
    localparam int unsigned OP_MTLO  = 8;
    localparam int unsigned OP_MADD  = 9;
    localparam int unsigned OP_MADDU = 10;
    localparam int unsigned OP_MSUB  = 11;
    localparam int unsigned OP_MSUBU = 12;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    // Ops that occupy the iterative datapath (multiply, divide, accumulate).
    function automatic logic is_start(input int unsigned code);
        return ((code >= OP_MULT) && (code <= OP_DIVU)) ||
               ((code >= OP_MADD) && (code <= OP_MSUBU));
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on the combined {upper, lower} working register.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
        trial = acc_in[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, operand};
        if (is_div) begin
            if (diff[WIDTH]) begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit with accumulate modes and flush.
// Operands are taken as magnitudes; signs are restored in the FIX state.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = mdu_pkg::OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [OPW-1:0]   op,
    input  logic             flush,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] dataout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   raw_a_reg;
    logic               is_div_reg;
    logic               accum_reg;
    logic               acc_sub_reg;
    logic               neg_res_reg;
    logic               neg_rem_reg;
    logic               div_zero_reg;
    logic               busy_reg;

    int unsigned        op_val;
    logic               signed_op;
    logic               div_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;
    logic [2*WIDTH-1:0] acc_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_raw;
    logic [WIDTH-1:0]   r_raw;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] result;

    assign op_val    = 32'(op);
    assign start     = is_start(op_val);
    assign busy      = busy_reg;
    assign signed_op = (op_val == OP_MULT) || (op_val == OP_DIV) ||
                       (op_val == OP_MADD) || (op_val == OP_MSUB);
    assign div_op    = (op_val == OP_DIV) || (op_val == OP_DIVU);
    assign a_neg     = signed_op & dataA[WIDTH-1];
    assign b_neg     = signed_op & dataB[WIDTH-1];
    assign abs_a     = a_neg ? -dataA : dataA;
    assign abs_b     = b_neg ? -dataB : dataB;
    // A new op may start from IDLE or in the FIX cycle of the previous one.
    assign accept    = start && !flush && ((state_reg == IDLE) || (state_reg == FIX));

    always_comb begin
        dataout = '0;
        if (op_val == OP_MFHI) begin
            dataout = hi_reg;
        end else if (op_val == OP_MFLO) begin
            dataout = lo_reg;
        end
    end

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_in (acc_reg),
        .operand(opnd_reg),
        .is_div (is_div_reg),
        .acc_out(acc_next)
    );

    always_comb begin
        prod_fix = neg_res_reg ? -acc_reg : acc_reg;
        q_raw    = acc_reg[WIDTH-1:0];
        r_raw    = acc_reg[2*WIDTH-1:WIDTH];
        q_fix    = neg_res_reg ? -q_raw : q_raw;
        r_fix    = neg_rem_reg ? -r_raw : r_raw;
        if (is_div_reg) begin
            // Division by zero reports the untouched dividend, no sign fix.
            result = div_zero_reg ? {raw_a_reg, {WIDTH{1'b1}}} : {r_fix, q_fix};
        end else if (accum_reg) begin
            result = acc_sub_reg ? ({hi_reg, lo_reg} - prod_fix)
                                 : ({hi_reg, lo_reg} + prod_fix);
        end else begin
            result = prod_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            raw_a_reg    <= '0;
            is_div_reg   <= 1'b0;
            accum_reg    <= 1'b0;
            acc_sub_reg  <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!flush) begin
                        if (op_val == OP_MTHI) begin
                            hi_reg <= dataA;
                        end else if (op_val == OP_MTLO) begin
                            lo_reg <= dataA;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg - CW'(1);
                        if (cnt_reg == CW'(1)) begin
                            state_reg <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (!flush) begin
                        hi_reg <= result[2*WIDTH-1:WIDTH];
                        lo_reg <= result[WIDTH-1:0];
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            // Acceptance overrides the state/busy updates above.
            if (accept) begin
                state_reg    <= CALC;
                busy_reg     <= 1'b1;
                cnt_reg      <= CW'(WIDTH);
                acc_reg      <= {{WIDTH{1'b0}}, abs_a};
                opnd_reg     <= abs_b;
                raw_a_reg    <= dataA;
                is_div_reg   <= div_op;
                accum_reg    <= (op_val >= OP_MADD) && (op_val <= OP_MSUBU);
                acc_sub_reg  <= (op_val == OP_MSUB) || (op_val == OP_MSUBU);
                neg_res_reg  <= a_neg ^ b_neg;
                neg_rem_reg  <= a_neg;
                div_zero_reg <= (dataB == '0);
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expected HI/LO pairs are queued at issue
// and compared when the unit goes idle; a second instance covers WIDTH=8.
module tb_mdu_iter;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;
    localparam logic [3:0] MADD  = 4'd9;
    localparam logic [3:0] MADDU = 4'd10;
    localparam logic [3:0] MSUB  = 4'd11;
    localparam logic [3:0] MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA, dataB, dataout;
    logic [3:0]  op;
    logic        flush, start, busy;
    logic [7:0]  a8, b8, dout8;
    logic [3:0]  op8;
    logic        flush8, start8, busy8;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_hilo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .op(op),
        .flush(flush), .start(start), .busy(busy), .dataout(dataout)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .dataA(a8), .dataB(b8), .op(op8),
        .flush(flush8), .start(start8), .busy(busy8), .dataout(dout8)
    );

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = hl;
        case (o)
            MULT:  p = 64'(sa * sb);
            MULTU: p = ua * ub;
            DIV: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else begin
                    p[31:0]  = 32'(sa / sb);
                    p[63:32] = 32'(sa % sb);
                end
            end
            DIVU: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {32'(ua % ub), 32'(ua / ub)};
            end
            MADD:  p = hl + 64'(sa * sb);
            MADDU: p = hl + ua * ub;
            MSUB:  p = hl - 64'(sa * sb);
            MSUBU: p = hl - ua * ub;
            default: p = hl;
        endcase
        return p;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; dataA = a; dataB = b;
        @(posedge clk);
        #1 op = NONE;
    endtask

    task automatic push_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expv);
        exp_q.push_back(expv);
        issue(o, a, b);
    endtask

    // Counts negedges with busy high; returns at the first negedge it is low.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        op = MFHI; #1 h = dataout;
        op = MFLO; #1 l = dataout;
        op = NONE; #1;
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        read_hilo(h, l);
        tests_run++;
        if ({busy, h, l} !== 65'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy/hi/lo=%b/%h/%h required 0/0/0", busy, h, l);
        end
        model_hilo = 64'd0;
        $display("[TB] reset: busy=%b hi=%h lo=%h", busy, h, l);
    endtask

    task automatic test_start();
        logic [3:0]  ops[5]   = '{DIVU, MSUBU, MFHI, MTLO, 4'd13};
        logic        exps[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op = ops[i]; flush = 1'b1;
            #1;
            tests_run++;
            if (start !== exps[i]) begin
                tests_failed++;
                $display("FAIL start_decode op=%0d: start=%b required %b", ops[i], start, exps[i]);
            end
            $display("[TB] start decode op=%0d start=%b", ops[i], start);
        end
        op = NONE;
        @(negedge clk) flush = 1'b0;
    endtask

    // Fixed-vector multiply/divide cases, each checked for result and latency.
    task automatic test_muldiv();
        logic [3:0]  ops[5] = '{MULT, MULTU, DIV, DIVU, DIV};
        logic [31:0] as[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] ex[5]  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE,
                                64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0005_FFFF_FFFF,
                                64'h0000_0000_8000_0000};
        logic [31:0] h, l;
        logic [63:0] expv;
        int          cyc;
        for (int i = 0; i < 5; i++) begin
            push_op(ops[i], as[i], bs[i], ex[i]);
            wait_idle(cyc);
            read_hilo(h, l);
            expv = exp_q.pop_front();
            model_hilo = expv;
            tests_run++;
            if ({h, l} !== expv) begin
                tests_failed++;
                $display("FAIL muldiv[%0d]: hi/lo=%h/%h required %h", i, h, l, expv);
            end
            tests_run++;
            if (cyc !== 33) begin
                tests_failed++;
                $display("FAIL busy_len[%0d]: %0d cycles required 33", i, cyc);
            end
            $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", ops[i], as[i], bs[i], h, l, cyc);
        end
    endtask

    task automatic test_accum();
        logic [31:0] h, l;
        logic [63:0] expv;
        int          cyc;
        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd5, 32'd0);
        read_hilo(h, l);
        tests_run++;
        if (l !== 32'd5) begin
            tests_failed++;
            $display("FAIL mflo_after_mtlo: lo=%h required 00000005", l);
        end
        $display("[TB] mtlo 5 -> mflo=%h", l);
        model_hilo = 64'd5;
        push_op(MADD, 32'd3, 32'd4, 64'd17);
        wait_idle(cyc);
        read_hilo(h, l);
        expv = exp_q.pop_front();
        tests_run++;
        if ({h, l} !== expv) begin
            tests_failed++;
            $display("FAIL madd: hi/lo=%h/%h required %h", h, l, expv);
        end
        $display("[TB] madd 3x4 -> hi=%h lo=%h", h, l);
        push_op(MSUBU, 32'd1, 32'd18, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(cyc);
        read_hilo(h, l);
        expv = exp_q.pop_front();
        model_hilo = expv;
        tests_run++;
        if ({h, l} !== expv) begin
            tests_failed++;
            $display("FAIL msubu: hi/lo=%h/%h required %h", h, l, expv);
        end
        $display("[TB] msubu 1x18 -> hi=%h lo=%h", h, l);
    endtask

    task automatic test_random();
        logic [3:0]  pool[8] = '{MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
        logic [3:0]  o;
        logic [31:0] a, b, h, l;
        logic [63:0] expv;
        int          cyc;
        for (int i = 0; i < 10; i++) begin
            o = pool[$urandom_range(0, 7)];
            a = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b = (i == 4) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50)));
            if ($urandom_range(0, 1) == 1) b = -b;
            push_op(o, a, b, model(o, a, b, model_hilo));
            wait_idle(cyc);
            read_hilo(h, l);
            expv = exp_q.pop_front();
            model_hilo = expv;
            tests_run++;
            if ({h, l} !== expv) begin
                tests_failed++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi/lo=%h/%h required %h", i, o, a, b, h, l, expv);
            end
            $display("[TB] rand op=%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, h, l);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l;
        logic [63:0] expv;
        int          cyc;
        push_op(MULTU, 32'd3, 32'd5, 64'd15);
        for (int i = 1; i <= 33; i++) @(negedge clk);
        exp_q.push_back(64'd29);
        op = MADDU; dataA = 32'd2; dataB = 32'd7;
        @(posedge clk);
        #1 op = NONE;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_busy: busy=%b required 1", busy);
        end
        read_hilo(h, l);
        expv = exp_q.pop_front();
        tests_run++;
        if ({h, l} !== expv) begin
            tests_failed++;
            $display("FAIL b2b_first: hi/lo=%h/%h required %h", h, l, expv);
        end
        wait_idle(cyc);
        read_hilo(h, l);
        expv = exp_q.pop_front();
        model_hilo = expv;
        tests_run++;
        if ({h, l, cyc} !== {expv, 32'd32}) begin
            tests_failed++;
            $display("FAIL b2b_second: hi/lo=%h/%h busy_rest=%0d required %h/32", h, l, cyc, expv);
        end
        $display("[TB] back-to-back multu 3x5, maddu 2x7 -> hi=%h lo=%h", h, l);
    endtask

    task automatic test_flush();
        logic [31:0] h, l;
        logic [63:0] expv;
        int          cyc;
        issue(MULT, 32'd7, 32'd9);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        read_hilo(h, l);
        tests_run++;
        if ({busy, h, l} !== {1'b0, model_hilo}) begin
            tests_failed++;
            $display("FAIL flush_calc: busy/hi/lo=%b/%h/%h required 0/%h", busy, h, l, model_hilo);
        end
        $display("[TB] flush mid-mult: busy=%b hi=%h lo=%h", busy, h, l);
        push_op(MULTU, 32'd6, 32'd7, 64'd42);
        wait_idle(cyc);
        read_hilo(h, l);
        expv = exp_q.pop_front();
        model_hilo = expv;
        tests_run++;
        if ({h, l} !== expv) begin
            tests_failed++;
            $display("FAIL after_flush: hi/lo=%h/%h required %h", h, l, expv);
        end
        @(negedge clk);
        op = MTHI; dataA = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk);
        #1 op = NONE; flush = 1'b0;
        read_hilo(h, l);
        tests_run++;
        if (h !== model_hilo[63:32]) begin
            tests_failed++;
            $display("FAIL flush_mthi: hi=%h required %h", h, model_hilo[63:32]);
        end
        $display("[TB] mthi with flush -> hi=%h", h);
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        issue(DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        read_hilo(h, l);
        tests_run++;
        if ({busy, h, l} !== 65'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy/hi/lo=%b/%h/%h required 0/0/0", busy, h, l);
        end
        reset = 1'b1;
        model_hilo = 64'd0;
        $display("[TB] reset mid-div: busy=%b hi=%h lo=%h", busy, h, l);
    endtask

    task automatic test_w8();
        logic [7:0]  h, l;
        logic [63:0] expv;
        int          cyc;
        exp_q.push_back(64'hFE01);
        @(negedge clk);
        op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk);
        #1 op8 = NONE;
        cyc = 0;
        @(negedge clk);
        while (busy8 === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        op8 = MFHI; #1 h = dout8;
        op8 = MFLO; #1 l = dout8;
        op8 = NONE;
        expv = exp_q.pop_front();
        tests_run++;
        if ({h, l} !== expv[15:0]) begin
            tests_failed++;
            $display("FAIL w8_multu: hi/lo=%h/%h required %h", h, l, expv[15:0]);
        end
        tests_run++;
        if (cyc !== 9) begin
            tests_failed++;
            $display("FAIL w8_busy: %0d cycles required 9", cyc);
        end
        $display("[TB] w8 multu ff x ff -> hi=%h lo=%h busy=%0d", h, l, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; op = NONE; dataA = '0; dataB = '0; flush = 1'b0;
        op8 = NONE; a8 = '0; b8 = '0; flush8 = 1'b0;
        model_hilo = 64'd0;
        test_reset();
        test_start();
        test_muldiv();
        test_accum();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_w8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
